nios2_ocimem_arbiter: RTL and testbench



---
 rtl/nios2_ocimem_pkg.sv | 21 ++
 rtl/nios2_ocimem_jtag_slot.sv | 72 +++++++
 rtl/nios2_ocimem_arbiter.sv | 116 +++++++++++
 tb/tb_nios2_ocimem_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_ocimem_pkg.sv
// Shared types and jdo field positions for the Nios II OCI RAM arbiter.
package nios2_ocimem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CPU_RD,
        ST_JTAG_RD
    } state_t;

    typedef enum logic {
        GNT_CPU,
        GNT_JTAG
    } grant_t;

    localparam int JDO_RDFLAG    = 17;
    localparam int JDO_ADDR_LSB  = 18;
    localparam int JDO_WDATA_LSB = 3;

    localparam logic [3:0] BYTEEN_ALL = 4'hF;

endpackage

// File: rtl/nios2_ocimem_jtag_slot.sv
// JTAG command slot: decodes debug strobes into a one-deep command register,
// keeps the auto-incrementing JTAG address and the sticky overrun flag.
module nios2_ocimem_jtag_slot
    import nios2_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [37:0]       jdo,
    input  logic              slot_take,
    output logic              slot_full,
    output logic              slot_wr,
    output logic [ADDR_W-1:0] slot_addr,
    output logic [DATA_W-1:0] slot_wdata,
    output logic              jtag_overrun
);

    logic [ADDR_W-1:0] jaddr_reg;
    logic [ADDR_W-1:0] jdo_addr;
    logic              jdo_rdflag;
    logic              any_strobe;
    logic              room;
    logic              unused_jdo;

    assign jdo_addr   = jdo[JDO_ADDR_LSB +: ADDR_W];
    assign jdo_rdflag = jdo[JDO_RDFLAG];
    assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    // A slot being granted this cycle can be refilled in the same cycle.
    assign room       = !slot_full || slot_take;
    assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_full    <= 1'b0;
            slot_wr      <= 1'b0;
            slot_addr    <= '0;
            slot_wdata   <= '0;
            jaddr_reg    <= '0;
            jtag_overrun <= 1'b0;
        end else begin
            if (slot_take)
                slot_full <= 1'b0;
            if (any_strobe && !room) begin
                jtag_overrun <= 1'b1;
            end else if (take_action_ocimem_a) begin
                jaddr_reg <= jdo_addr + {{(ADDR_W-1){1'b0}}, jdo_rdflag};
                if (jdo_rdflag) begin
                    slot_full <= 1'b1;
                    slot_wr   <= 1'b0;
                    slot_addr <= jdo_addr;
                end
            end else if (take_no_action_ocimem_a) begin
                slot_full <= 1'b1;
                slot_wr   <= 1'b0;
                slot_addr <= jaddr_reg;
                jaddr_reg <= jaddr_reg + 1'b1;
            end else if (take_action_ocimem_b) begin
                slot_full  <= 1'b1;
                slot_wr    <= 1'b1;
                slot_addr  <= jaddr_reg;
                slot_wdata <= jdo[JDO_WDATA_LSB +: DATA_W];
                jaddr_reg  <= jaddr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/nios2_ocimem_arbiter.sv
// Shares the single-port OCI RAM between the JTAG debug slot and the CPU
// Avalon debug slave, round-robin on contention.
module nios2_ocimem_arbiter
    import nios2_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [37:0]       jdo,
    output logic [DATA_W-1:0] MonDReg,
    output logic              mon_valid,
    output logic              jtag_overrun,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [3:0]        ram_byteen,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_t            state_reg;
    grant_t            last_grant_reg;
    logic [DATA_W-1:0] rdata_hold_reg;
    logic              slot_full;
    logic              slot_wr;
    logic [ADDR_W-1:0] slot_addr;
    logic [DATA_W-1:0] slot_wdata;
    logic              cpu_req;
    logic              contended;
    logic              grant_cpu;
    logic              grant_jtag;

    nios2_ocimem_jtag_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .jdo                     (jdo),
        .slot_take               (grant_jtag),
        .slot_full               (slot_full),
        .slot_wr                 (slot_wr),
        .slot_addr               (slot_addr),
        .slot_wdata              (slot_wdata),
        .jtag_overrun            (jtag_overrun)
    );

    assign cpu_req = avs_read | avs_write;

    always_comb begin
        contended  = 1'b0;
        grant_cpu  = 1'b0;
        grant_jtag = 1'b0;
        if (state_reg == ST_IDLE) begin
            if (slot_full && cpu_req) begin
                contended  = 1'b1;
                grant_jtag = (last_grant_reg == GNT_CPU);
                grant_cpu  = (last_grant_reg == GNT_JTAG);
            end else begin
                grant_jtag = slot_full;
                grant_cpu  = cpu_req;
            end
        end
    end

    // RAM port is steered combinationally so that grants hit the RAM in the grant cycle.
    assign ram_addr        = grant_jtag ? slot_addr  : avs_address;
    assign ram_wren        = (grant_cpu && avs_write) || (grant_jtag && slot_wr);
    assign ram_byteen      = grant_jtag ? BYTEEN_ALL : avs_byteenable;
    assign ram_wdata       = grant_jtag ? slot_wdata : avs_writedata;
    assign avs_waitrequest = cpu_req && !((grant_cpu && avs_write) || (state_reg == ST_CPU_RD));
    assign avs_readdata    = (state_reg == ST_CPU_RD) ? ram_rdata : rdata_hold_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= GNT_CPU;
            rdata_hold_reg <= '0;
            MonDReg        <= '0;
            mon_valid      <= 1'b0;
        end else begin
            mon_valid <= (state_reg == ST_JTAG_RD);
            case (state_reg)
                ST_IDLE: begin
                    if (contended)
                        last_grant_reg <= grant_jtag ? GNT_JTAG : GNT_CPU;
                    if (grant_jtag && !slot_wr)
                        state_reg <= ST_JTAG_RD;
                    else if (grant_cpu && avs_read)
                        state_reg <= ST_CPU_RD;
                end
                ST_CPU_RD: begin
                    rdata_hold_reg <= ram_rdata;
                    state_reg      <= ST_IDLE;
                end
                ST_JTAG_RD: begin
                    MonDReg   <= ram_rdata;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nios2_ocimem_arbiter.sv
// Randomized bench for nios2_ocimem_arbiter with a per-cycle behavioural model
// and a RAM stand-in, plus directed scenarios with literal expectations.
module tb_nios2_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        take_action_ocimem_a = 1'b0;
    logic        take_no_action_ocimem_a = 1'b0;
    logic        take_action_ocimem_b = 1'b0;
    logic [37:0] jdo = '0;
    logic [31:0] MonDReg;
    logic        mon_valid;
    logic        jtag_overrun;
    logic [7:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [3:0]  avs_byteenable = '0;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [7:0]  ram_addr;
    logic        ram_wren;
    logic [3:0]  ram_byteen;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;

    int n_checks = 0;
    int n_fail   = 0;

    nios2_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .jdo                     (jdo),
        .MonDReg                 (MonDReg),
        .mon_valid               (mon_valid),
        .jtag_overrun            (jtag_overrun),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest),
        .ram_addr                (ram_addr),
        .ram_wren                (ram_wren),
        .ram_byteen              (ram_byteen),
        .ram_wdata               (ram_wdata),
        .ram_rdata               (ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM stand-in: single port, registered read, byte-enabled write.
    logic [31:0] mem [256];
    logic [31:0] exp_mem [256];

    always @(posedge clk) begin
        if (ram_wren)
            for (int b = 0; b < 4; b++)
                if (ram_byteen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one pending JTAG command, one read in flight at most.
    int          m_inflight;   // 0 none, 1 CPU read data due now, 2 JTAG read data due now
    bit          ms_full, ms_wr;
    logic [7:0]  ms_addr;
    logic [31:0] ms_data;
    logic [7:0]  m_jaddr;
    bit          m_last_jtag, m_overrun, m_pulse;
    logic [31:0] m_mon, m_hold, m_rdval;

    int          win;          // 0 nobody, 1 CPU, 2 JTAG
    bit          e_wren, e_wait, full_eff, contest;
    logic [7:0]  e_addr, ja;
    logic [3:0]  e_be;
    logic [31:0] e_wd;

    always @(negedge clk) begin
        if (!reset_n) begin
            m_inflight = 0; ms_full = 0; ms_wr = 0; ms_addr = 0; ms_data = 0;
            m_jaddr = 0; m_last_jtag = 0; m_overrun = 0; m_pulse = 0;
            m_mon = 0; m_hold = 0; m_rdval = 0;
        end else begin
            win = 0;
            contest = 0;
            if (m_inflight == 0) begin
                if (ms_full && (avs_read || avs_write)) begin
                    contest = 1;
                    win = m_last_jtag ? 1 : 2;
                end else if (ms_full) win = 2;
                else if (avs_read || avs_write) win = 1;
            end
            e_addr = (win == 2) ? ms_addr : avs_address;
            e_wren = (win == 1 && avs_write) || (win == 2 && ms_wr);
            e_be   = (win == 2) ? 4'hF : avs_byteenable;
            e_wd   = (win == 2) ? ms_data : avs_writedata;
            e_wait = (avs_read || avs_write) && !((win == 1 && avs_write) || m_inflight == 1);

            if (win != 0 || m_inflight == 0) chk("ram_addr", ram_addr, e_addr);
            chk("ram_wren", ram_wren, e_wren);
            if (e_wren) begin
                chk("ram_byteen", ram_byteen, e_be);
                chk("ram_wdata", ram_wdata, e_wd);
            end
            chk("waitrequest", avs_waitrequest, e_wait);
            if (m_inflight == 1) chk("avs_readdata", avs_readdata, m_rdval);
            chk("mon_valid", mon_valid, m_pulse);
            chk("MonDReg", MonDReg, m_mon);
            chk("overrun", jtag_overrun, m_overrun);

            // advance to the state after the coming clock edge
            m_pulse = (m_inflight == 2);
            if (m_inflight == 2) m_mon = m_rdval;
            if (m_inflight == 1) m_hold = m_rdval;
            m_inflight = 0;
            if (e_wren) begin
                for (int b = 0; b < 4; b++)
                    if (e_be[b]) exp_mem[e_addr][8*b +: 8] = e_wd[8*b +: 8];
            end else if (win == 1 && avs_read) begin
                m_rdval = exp_mem[e_addr];
                m_inflight = 1;
            end else if (win == 2) begin
                m_rdval = exp_mem[e_addr];
                m_inflight = 2;
            end
            if (contest) m_last_jtag = (win == 2);
            full_eff = ms_full && (win != 2);
            ms_full  = full_eff;
            if ((take_action_ocimem_a || take_no_action_ocimem_a || take_action_ocimem_b) && full_eff) begin
                m_overrun = 1;
            end else if (take_action_ocimem_a) begin
                ja = jdo[25:18];
                if (jdo[17]) begin
                    ms_full = 1; ms_wr = 0; ms_addr = ja; m_jaddr = ja + 8'd1;
                end else begin
                    m_jaddr = ja;
                end
            end else if (take_no_action_ocimem_a) begin
                ms_full = 1; ms_wr = 0; ms_addr = m_jaddr; m_jaddr = m_jaddr + 8'd1;
            end else if (take_action_ocimem_b) begin
                ms_full = 1; ms_wr = 1; ms_addr = m_jaddr; ms_data = jdo[34:3];
                m_jaddr = m_jaddr + 8'd1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
    endtask

    // kind: 0 = action_a, 1 = no_action_a, 2 = action_b; one strobe cycle.
    task automatic jstrobe(input int kind, input logic [37:0] jv);
        jdo = jv;
        take_action_ocimem_a    = (kind == 0);
        take_no_action_ocimem_a = (kind == 1);
        take_action_ocimem_b    = (kind == 2);
        step();
        take_action_ocimem_a    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b    = 1'b0;
    endtask

    task automatic cpu_access(input bit wr, input logic [7:0] a, input logic [31:0] d,
                              input logic [3:0] be, output int waits, output logic [31:0] rd);
        bit w;
        avs_address = a; avs_writedata = d; avs_byteenable = be;
        avs_read = !wr; avs_write = wr;
        waits = 0;
        rd = '0;
        for (int n = 0; n < 20; n++) begin
            #2;
            w  = avs_waitrequest;
            rd = avs_readdata;
            step();
            if (!w) break;
            waits++;
        end
        if (waits >= 20) chk("cpu_timeout", 32'(waits), 32'd0);
        avs_read = 1'b0; avs_write = 1'b0;
    endtask

    function automatic logic [37:0] jdo_a(input logic [7:0] a, input bit rd);
        logic [37:0] v;
        v = '0;
        v[25:18] = a;
        v[17] = rd;
        return v;
    endfunction

    function automatic logic [37:0] jdo_w(input logic [31:0] d);
        logic [37:0] v;
        v = '0;
        v[34:3] = d;
        return v;
    endfunction

    int          n, w1, w2;
    logic [31:0] rd1, rd2;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            exp_mem[i] = mem[i];
        end
        mem[8'h10] = 32'hDEADBEEF; exp_mem[8'h10] = 32'hDEADBEEF;
        mem[8'h20] = 32'h12345678; exp_mem[8'h20] = 32'h12345678;

        repeat (3) step();
        reset_n = 1'b1;
        #2;
        chk("rst_MonDReg", MonDReg, 32'h0);
        chk("rst_mon_valid", mon_valid, 1'b0);
        chk("rst_overrun", jtag_overrun, 1'b0);
        chk("rst_wren", ram_wren, 1'b0);
        chk("rst_readdata", avs_readdata, 32'h0);
        step();

        // JTAG read at 0x10: mon_valid two cycles after the slot fills
        jstrobe(0, jdo_a(8'h10, 1'b1));
        n = 0;
        while (n < 10) begin
            #2;
            if (mon_valid) break;
            step();
            n++;
        end
        chk("jrd_latency", 32'(n), 32'd2);
        chk("jrd_data", MonDReg, 32'hDEADBEEF);
        step();
        jstrobe(1, '0);
        #2;
        chk("jaddr_inc", ram_addr, 8'h11);
        chk("jaddr_rd_wren", ram_wren, 1'b0);
        step();
        repeat (3) step();

        // JTAG writes across the address wrap
        jstrobe(0, jdo_a(8'hFE, 1'b0));
        repeat (3) step();
        for (int k = 1; k <= 3; k++) begin
            jstrobe(2, jdo_w(32'(k)));
            repeat (3) step();
        end
        chk("wr_FE", mem[8'hFE], 32'd1);
        chk("wr_FF", mem[8'hFF], 32'd2);
        chk("wr_00", mem[8'h00], 32'd3);

        // uncontested CPU read and byte-masked write
        cpu_access(1'b0, 8'h20, '0, 4'hF, w1, rd1);
        chk("cpu_rd_waits", 32'(w1), 32'd1);
        chk("cpu_rd_data", rd1, 32'h12345678);
        avs_address = 8'h30; avs_writedata = 32'hA5A5C3C3; avs_byteenable = 4'b0011;
        avs_write = 1'b1;
        #2;
        chk("cpu_wr_wren", ram_wren, 1'b1);
        chk("cpu_wr_byteen", ram_byteen, 4'b0011);
        chk("cpu_wr_wait", avs_waitrequest, 1'b0);
        step();
        avs_write = 1'b0;
        step();
        chk("cpu_wr_mem", mem[8'h30][15:0], 32'h0000C3C3);

        // contention right after reset: JTAG first, then CPU first
        do_reset();
        fork
            jstrobe(0, jdo_a(8'h40, 1'b1));
            begin step(); cpu_access(1'b0, 8'h41, '0, 4'hF, w1, rd1); end
        join
        repeat (4) step();
        fork
            jstrobe(0, jdo_a(8'h42, 1'b1));
            begin step(); cpu_access(1'b0, 8'h43, '0, 4'hF, w2, rd2); end
        join
        repeat (4) step();
        chk("contend_jtag_first", 32'(w1), 32'd3);
        chk("contend_cpu_first", 32'(w2), 32'd1);
        chk("contend_cpu_data", rd2, exp_mem[8'h43]);

        // overrun: second strobe lands while the first is still waiting
        chk("pre_overrun", jtag_overrun, 1'b0);
        fork
            cpu_access(1'b0, 8'h50, '0, 4'hF, w1, rd1);
            begin jstrobe(1, '0); jstrobe(2, jdo_w(32'hBAD0BAD0)); end
        join
        #2;
        chk("overrun_set", jtag_overrun, 1'b1);
        step();
        repeat (5) step();
        chk("overrun_sticky", jtag_overrun, 1'b1);

        // randomized traffic, checked cycle by cycle by the model
        for (int it = 0; it < 250; it++) begin
            int r;
            int kind;
            logic [37:0] jv;
            r = $urandom_range(0, 9);
            kind = $urandom_range(0, 2);
            jv = {6'($urandom), $urandom};
            if (r <= 2) begin
                step();
            end else if (r <= 4) begin
                jstrobe(kind, jv);
            end else if (r <= 6) begin
                cpu_access(1'($urandom), 8'($urandom), $urandom, 4'($urandom), w1, rd1);
            end else begin
                fork
                    jstrobe(kind, jv);
                    cpu_access(1'($urandom), 8'($urandom), $urandom, 4'($urandom), w1, rd1);
                join
            end
        end
        repeat (4) step();

        // reset asserted during the JTAG read-data cycle
        jstrobe(0, jdo_a(8'h10, 1'b1));
        step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("rstmid_mon_valid", mon_valid, 1'b0);
        chk("rstmid_MonDReg", MonDReg, 32'h0);
        chk("rstmid_overrun", jtag_overrun, 1'b0);
        chk("rstmid_wren", ram_wren, 1'b0);
        chk("rstmid_readdata", avs_readdata, 32'h0);
        step();
        #2;
        chk("rstmid_no_pulse", mon_valid, 1'b0);
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #2;
            chk("rstmid_after_pulse", mon_valid, 1'b0);
            step();
        end
        chk("rstmid_after_MonDReg", MonDReg, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
